// File: rtl/display_scheduler_if.sv
// Requester-side bundle for display_scheduler: request/digit inputs, grant and display outputs.
interface display_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic                   ena;
    logic [NUM_REQ-1:0]     req;
    logic [4*NUM_REQ-1:0]   digit_in;
    logic [7:0]             dwell_sel;
    logic [NUM_REQ-1:0]     grant;
    logic [3:0]             digit_out;
    logic                   digit_valid;
    logic                   busy;

    modport master (
        output ena, req, digit_in, dwell_sel,
        input  grant, digit_out, digit_valid, busy
    );

    modport slave (
        input  ena, req, digit_in, dwell_sel,
        output grant, digit_out, digit_valid, busy
    );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin time-sharing of one seven-segment digit among NUM_REQ requesters.
// Optional blank gap between slots is compiled in with DISPLAY_SCHED_BLANK_EN.
module display_scheduler #(
    parameter int          NUM_REQ     = 4,
    parameter logic [23:0] DWELL_COUNT = 24'd10_000_000,
    parameter logic [15:0] BLANK_COUNT = 16'd50_000
) (
    input  logic            clk,
    input  logic            rst_n,
    display_scheduler_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_win;
    logic [23:0]        r_dwell_cnt;
    logic [23:0]        r_dwell_cmp;
    logic [NUM_REQ-1:0] r_grant;
    logic [3:0]         r_digit;
    logic               r_valid;
    logic               r_busy;
`ifdef DISPLAY_SCHED_BLANK_EN
    logic [15:0]        r_blank_cnt;
`endif

    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_next_ptr;
    logic [23:0]        w_dwell_cmp;
    logic               w_show_done;

    // First set request searching upward from r_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && bus.req[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
    end

    always_comb begin
        w_next_ptr  = (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
        w_dwell_cmp = (bus.dwell_sel == '0) ? DWELL_COUNT : {6'b0, bus.dwell_sel, 10'b0};
        w_show_done = (r_dwell_cnt == r_dwell_cmp) || !bus.req[r_win];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_dwell_cnt <= '0;
            r_dwell_cmp <= '0;
            r_grant     <= '0;
            r_digit     <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef DISPLAY_SCHED_BLANK_EN
            r_blank_cnt <= '0;
`endif
        end else if (bus.ena) begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= SHOW;
                        r_win       <= w_win;
                        r_grant     <= NUM_REQ'(1) << w_win;
                        r_digit     <= bus.digit_in[{w_win, 2'b00} +: 4];
                        r_dwell_cmp <= w_dwell_cmp;
                        r_dwell_cnt <= '0;
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                SHOW: begin
                    // Dwell expiry and release are one exit; coincidence changes nothing.
                    if (w_show_done) begin
                        r_grant     <= '0;
                        r_valid     <= 1'b0;
                        r_dwell_cnt <= '0;
                        r_ptr       <= w_next_ptr;
`ifdef DISPLAY_SCHED_BLANK_EN
                        r_state     <= BLANK;
`else
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
`endif
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 1'b1;
                    end
                end
`ifdef DISPLAY_SCHED_BLANK_EN
                BLANK: begin
                    if (r_blank_cnt == BLANK_COUNT) begin
                        r_blank_cnt <= '0;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                    end else begin
                        r_blank_cnt <= r_blank_cnt + 1'b1;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.digit_out   = r_digit;
    assign bus.digit_valid = r_valid;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler (DWELL_COUNT=8, BLANK_COUNT=2); follows DISPLAY_SCHED_BLANK_EN.
module tb_display_scheduler;
`ifdef DISPLAY_SCHED_BLANK_EN
    localparam int   GAP      = 4;
    localparam logic BUSY_GAP = 1'b1;
`else
    localparam int   GAP      = 1;
    localparam logic BUSY_GAP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   len;
    int   cnt;
    logic frz_ok;

    display_scheduler_if #(.NUM_REQ(4)) bus ();

    display_scheduler #(
        .NUM_REQ     (4),
        .DWELL_COUNT (24'd8),
        .BLANK_COUNT (16'd2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts samples with grant held, starting with the current one.
    task automatic measure_slot(output int n);
        n = 1;
        while (bus.grant != '0 && n < 20000) begin
            tick;
            if (bus.grant != '0) n++;
        end
    endtask

    task automatic measure_gap(output int n);
        n = 0;
        while (bus.grant == '0 && n < 20000) begin
            n++;
            tick;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.req = 4'b0000;
        bus.digit_in = 16'h0000;
        bus.dwell_sel = 8'd0;
        #3;
        check("rst_grant", bus.grant, 4'b0000);
        check("rst_digit", bus.digit_out, 4'h0);
        check("rst_valid", bus.digit_valid, 1'b0);
        check("rst_busy",  bus.busy, 1'b0);

        bus.req = 4'b0001;
        bus.digit_in = 16'hEA57;
        tick;
        check("rst_hold_grant", bus.grant, 4'b0000);
        rst_n = 1'b1;
        tick;
        check("first_grant", bus.grant, 4'b0001);
        check("first_digit", bus.digit_out, 4'h7);
        check("first_valid", bus.digit_valid, 1'b1);
        check("first_busy",  bus.busy, 1'b1);
        measure_slot(len);
        check("single_slot_len", len, 9);
        check("gap_valid", bus.digit_valid, 1'b0);
        check("gap_busy", bus.busy, BUSY_GAP);
        measure_gap(len);
        check("single_gap_len", len, GAP);
        check("regrant", bus.grant, 4'b0001);

        bus.req = 4'b1011;
        measure_slot(len);
        check("rr0_len", len, 9);
        measure_gap(len);
        check("rr0_gap", len, GAP);
        check("rr1_grant", bus.grant, 4'b0010);
        check("rr1_digit", bus.digit_out, 4'h5);
        measure_slot(len);
        check("rr1_len", len, 9);
        measure_gap(len);
        check("rr3_grant", bus.grant, 4'b1000);
        check("rr3_digit", bus.digit_out, 4'hE);
        measure_slot(len);
        check("rr3_len", len, 9);
        measure_gap(len);
        check("rr_wrap_grant", bus.grant, 4'b0001);
        check("rr_wrap_digit", bus.digit_out, 4'h7);

        tick;
        tick;
        bus.req = 4'b1010;
        tick;
        check("early_grant", bus.grant, 4'b0000);
        check("early_valid", bus.digit_valid, 1'b0);
        measure_gap(len);
        check("early_gap", len, GAP);
        check("early_ptr_grant", bus.grant, 4'b0010);

        bus.dwell_sel = 8'd1;
        measure_slot(len);
        check("dwell_latched_len", len, 9);
        measure_gap(len);
        check("dw1_grant", bus.grant, 4'b1000);
        tick;
        tick;
        tick;
        bus.dwell_sel = 8'd5;
        bus.digit_in = 16'h3A57;
        tick;
        check("digit_latched", bus.digit_out, 4'hE);
        measure_slot(len);
        check("dw1_len", len + 4, 1025);
        measure_gap(len);
        check("dw5_grant", bus.grant, 4'b0010);
        bus.dwell_sel = 8'd0;
        measure_slot(len);
        check("dw5_len", len, 5121);
        measure_gap(len);
        check("ena_grant", bus.grant, 4'b1000);
        check("ena_digit", bus.digit_out, 4'h3);

        tick;
        tick;
        bus.ena = 1'b0;
        frz_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.grant != 4'b1000 || bus.digit_valid != 1'b1 || bus.busy != 1'b1)
                frz_ok = 1'b0;
        end
        check("ena_frozen", frz_ok, 1'b1);
        bus.ena = 1'b1;
        measure_slot(len);
        cnt = 2 + len;
        check("ena_slot_len", cnt, 9);
        measure_gap(len);
        check("pre_rst_grant", bus.grant, 4'b0010);

        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_grant", bus.grant, 4'b0000);
        check("async_digit", bus.digit_out, 4'h0);
        check("async_valid", bus.digit_valid, 1'b0);
        check("async_busy",  bus.busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick;
        check("post_rst_grant", bus.grant, 4'b0010);

        for (int i = 0; i < 8; i++) tick;
        bus.req = 4'b1001;
        tick;
        check("coinc_exit", bus.grant, 4'b0000);
        measure_gap(len);
        check("coinc_gap", len, GAP);
        check("coinc_ptr_grant", bus.grant, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
